// File: rtl/fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fc_layer_sequencer
// Description : Walks N_OUT neurons x N_IN features for the fully-connected
//               layer. Issues feature/weight buffer reads, drives the shared
//               MAC (clear/enable/last), writes each neuron's result to the
//               logit buffer and tracks a running signed argmax.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_layer_sequencer #(
   parameter int N_IN    = 169,
   parameter int N_OUT   = 10,
   parameter int ACC_W   = 32,
   parameter int MEM_LAT = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              begin_fc,
   output logic                              rd_en,
   output logic [$clog2(N_IN)-1:0]           feat_addr,
   output logic [$clog2(N_IN*N_OUT)-1:0]     wt_addr,
   output logic                              mac_en,
   output logic                              mac_clear,
   output logic                              mac_last,
   input  logic                              acc_valid,
   input  logic signed [ACC_W-1:0]           acc_in,
   output logic                              out_wr_en,
   output logic [$clog2(N_OUT)-1:0]          out_idx,
   output logic signed [ACC_W-1:0]           out_data,
   output logic                              busy,
   output logic                              done,
   output logic [$clog2(N_OUT)-1:0]          class_idx,
   output logic signed [ACC_W-1:0]           class_score
);

   localparam int FA_W = $clog2(N_IN);
   localparam int WA_W = $clog2(N_IN*N_OUT);
   localparam int OI_W = $clog2(N_OUT);

   localparam logic [FA_W-1:0] c_K_LAST = FA_W'(N_IN-1);
   localparam logic [OI_W-1:0] c_N_LAST = OI_W'(N_OUT-1);
   localparam logic [WA_W-1:0] c_WSTEP  = WA_W'(N_IN);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t                  r_state;
   logic [FA_W-1:0]         r_k;
   logic [OI_W-1:0]         r_neuron;
   logic [WA_W-1:0]         r_wbase;
   logic                    r_rd_first;
   logic                    r_rd_last;
   logic signed [ACC_W-1:0] r_best;
   logic [OI_W-1:0]         r_best_idx;
   logic [2:0]              r_pipe [MEM_LAT];
   logic                    w_better;

   // First neuron always seeds the argmax; later ones must be strictly larger
   // so that ties keep the lower index.
   assign w_better = (r_neuron == '0) || (acc_in > r_best);

   // MAC controls are the read tags aged by the buffer latency, so they line
   // up with the data arriving at the MAC inputs.
   assign {mac_en, mac_clear, mac_last} = r_pipe[MEM_LAT-1];

   // Control FSM: read issue, result collection, argmax and completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_neuron    <= '0;
         r_wbase     <= '0;
         r_rd_first  <= 1'b0;
         r_rd_last   <= 1'b0;
         r_best      <= '0;
         r_best_idx  <= '0;
         rd_en       <= 1'b0;
         feat_addr   <= '0;
         wt_addr     <= '0;
         out_wr_en   <= 1'b0;
         out_idx     <= '0;
         out_data    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         class_idx   <= '0;
         class_score <= '0;
      end else begin
         rd_en      <= 1'b0;
         r_rd_first <= 1'b0;
         r_rd_last  <= 1'b0;
         out_wr_en  <= 1'b0;
         done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (begin_fc) begin
                  r_neuron <= '0;
                  r_k      <= '0;
                  r_wbase  <= '0;
                  busy     <= 1'b1;
                  r_state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               rd_en      <= 1'b1;
               feat_addr  <= r_k;
               wt_addr    <= r_wbase + WA_W'(r_k);
               r_rd_first <= (r_k == '0);
               r_rd_last  <= (r_k == c_K_LAST);
               // k parks at its last value rather than wrapping
               if (r_k == c_K_LAST) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            S_DRAIN: begin
               if (acc_valid) begin
                  out_wr_en <= 1'b1;
                  out_idx   <= r_neuron;
                  out_data  <= acc_in;
                  if (w_better) begin
                     r_best     <= acc_in;
                     r_best_idx <= r_neuron;
                  end
                  if (r_neuron == c_N_LAST) begin
                     r_state <= S_FINISH;
                  end else begin
                     r_neuron <= r_neuron + 1'b1;
                     r_wbase  <= r_wbase + c_WSTEP;
                     r_k      <= '0;
                     r_state  <= S_ISSUE;
                  end
               end
            end
            S_FINISH: begin
               class_idx   <= r_best_idx;
               class_score <= r_best;
               done        <= 1'b1;
               busy        <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Delay line carrying {read, first term, last term} by MEM_LAT cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MEM_LAT; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= {rd_en, r_rd_first, r_rd_last};
         for (int i = 1; i < MEM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_layer_sequencer
// Description : Directed self-checking bench for fc_layer_sequencer with
//               N_IN=4, N_OUT=3, MEM_LAT=1 and a behavioural 2-cycle MAC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_layer_sequencer;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              begin_fc = 1'b0;
   logic              rd_en;
   logic [1:0]        feat_addr;
   logic [3:0]        wt_addr;
   logic              mac_en, mac_clear, mac_last;
   logic              acc_valid;
   logic signed [31:0] acc_in;
   logic              out_wr_en;
   logic [1:0]        out_idx;
   logic signed [31:0] out_data;
   logic              busy, done;
   logic [1:0]        class_idx;
   logic signed [31:0] class_score;

   fc_layer_sequencer #(.N_IN(4), .N_OUT(3), .ACC_W(32), .MEM_LAT(1)) dut (
      .clk(clk), .reset(reset), .begin_fc(begin_fc),
      .rd_en(rd_en), .feat_addr(feat_addr), .wt_addr(wt_addr),
      .mac_en(mac_en), .mac_clear(mac_clear), .mac_last(mac_last),
      .acc_valid(acc_valid), .acc_in(acc_in),
      .out_wr_en(out_wr_en), .out_idx(out_idx), .out_data(out_data),
      .busy(busy), .done(done), .class_idx(class_idx), .class_score(class_score)
   );

   always #5 clk = ~clk;

   // ---------------- buffers and behavioural MAC ----------------
   logic signed [31:0] fmem [4];
   logic signed [31:0] wmem [12];
   logic signed [31:0] f_q, w_q, mac_acc, mac_res;
   int                 mac_lat = 2;
   int                 mac_cnt;

   // One-cycle buffer read, MAC accumulate, result pulse after mac_lat cycles.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         f_q <= 0; w_q <= 0; mac_acc <= 0; mac_res <= 0;
         mac_cnt <= 0; acc_valid <= 1'b0; acc_in <= 0;
      end else begin
         if (rd_en) begin
            f_q <= fmem[feat_addr];
            w_q <= wmem[wt_addr];
         end
         acc_valid <= 1'b0;
         if (mac_cnt == 1) begin
            acc_valid <= 1'b1;
            acc_in    <= mac_res;
         end
         if (mac_cnt > 0) mac_cnt <= mac_cnt - 1;
         if (mac_en) begin
            mac_acc <= (mac_clear ? 32'sd0 : mac_acc) + f_q * w_q;
            if (mac_last) begin
               mac_res <= (mac_clear ? 32'sd0 : mac_acc) + f_q * w_q;
               mac_cnt <= mac_lat;
            end
         end
      end
   end

   // ---------------- monitor (per-run counters) ----------------
   int                 n_rd, n_addr_bad, n_mac, n_seq_bad, n_wr, n_done;
   int                 wr_idx [8];
   logic signed [31:0] wr_data [8];
   logic               prev_busy = 1'b0;

   initial begin
      n_rd = 0; n_addr_bad = 0; n_mac = 0; n_seq_bad = 0; n_wr = 0; n_done = 0;
      forever begin
         @(negedge clk);
         if (reset || (busy && !prev_busy)) begin
            n_rd = 0; n_addr_bad = 0; n_mac = 0; n_seq_bad = 0; n_wr = 0; n_done = 0;
         end
         prev_busy = reset ? 1'b0 : busy;
         if (!reset) begin
            if (rd_en) begin
               if (int'(wt_addr) != n_rd || int'(feat_addr) != n_rd % 4) n_addr_bad++;
               n_rd++;
            end
            if (mac_en) begin
               if (mac_clear != (n_mac % 4 == 0) || mac_last != (n_mac % 4 == 3)) n_seq_bad++;
               n_mac++;
            end else if (mac_clear || mac_last) begin
               n_seq_bad++;
            end
            if (out_wr_en) begin
               if (n_wr < 8) begin
                  wr_idx[n_wr]  = int'(out_idx);
                  wr_data[n_wr] = out_data;
               end
               n_wr++;
            end
            if (done) n_done++;
         end
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, {rd_en, feat_addr, wt_addr, mac_en, mac_clear, mac_last,
                            out_wr_en, out_idx, busy, done, class_idx}, 0);
      check({tag, "_data"},  out_data, 0);
      check({tag, "_score"}, class_score, 0);
   endtask

   task automatic start_run();
      @(negedge clk);
      begin_fc = 1'b1;
      @(negedge clk);
      begin_fc = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      int n = 0;
      while (done !== 1'b1 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, longint'(n < max_cyc), 1);
      @(negedge clk);
   endtask

   task automatic check_run(input string tag, input longint e0, input longint e1,
                            input longint e2, input longint eidx, input longint escore);
      longint exp_l [3];
      exp_l = '{e0, e1, e2};
      check({tag, "_nwr"},   n_wr, 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_idx%0d", tag, i),   wr_idx[i], i);
         check($sformatf("%s_logit%0d", tag, i), wr_data[i], exp_l[i]);
      end
      check({tag, "_nrd"},     n_rd, 12);
      check({tag, "_addr"},    n_addr_bad, 0);
      check({tag, "_nmac"},    n_mac, 12);
      check({tag, "_macseq"},  n_seq_bad, 0);
      check({tag, "_ndone"},   n_done, 1);
      check({tag, "_busy"},    busy, 0);
      check({tag, "_cls"},     class_idx, eidx);
      check({tag, "_score"},   class_score, escore);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      fmem = '{1, 2, 3, 4};
      wmem = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

      // 1: reset, then idle with no begin_fc
      repeat (3) @(negedge clk);
      check_zero("rst_held");
      reset = 1'b0;
      @(negedge clk);
      check_zero("rst_rel");
      repeat (100) @(negedge clk);
      check("idle_nrd", n_rd, 0);
      check("idle_busy", busy, 0);

      // 2: all-ones weights, features 1..4
      start_run();
      check("run_busy", busy, 1);
      wait_done("t2", 200);
      check_run("t2", 10, 10, 10, 0, 10);

      // 3a: signed argmax with tie -> lower index
      wmem = '{-5, 0, 0, 0, 1, 0, 2, 0, 0, 2, 1, 0};
      start_run();
      wait_done("t3a", 200);
      check_run("t3a", -5, 7, 7, 1, 7);

      // 3b: all negative logits
      wmem = '{-3, 0, 0, 0, -1, -1, -2, 0, -1, 0, 0, 0};
      start_run();
      wait_done("t3b", 200);
      check_run("t3b", -3, -9, -1, 2, -1);

      // 4: begin_fc pulses during ISSUE and DRAIN are ignored
      wmem = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      start_run();
      @(negedge clk);
      begin_fc = 1'b1;
      @(negedge clk);
      begin_fc = 1'b0;
      for (int n = 0; n < 50 && mac_last !== 1'b1; n++) @(negedge clk);
      begin_fc = 1'b1;
      @(negedge clk);
      begin_fc = 1'b0;
      wait_done("t4", 200);
      check_run("t4", 10, 10, 10, 0, 10);
      repeat (10) @(negedge clk);
      check("t4_norestart", n_rd, 12);
      check("t4_idle", busy, 0);

      // 5: stalled MAC holds the sequencer in DRAIN
      wmem = '{2, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0};
      mac_lat = 22;
      start_run();
      for (int n = 0; n < 50 && n_mac < 4; n++) @(negedge clk);
      begin
         logic rd_seen = 1'b0;
         logic wr_seen = 1'b0;
         for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rd_seen |= rd_en;
            wr_seen |= out_wr_en;
         end
         check("t5_stall_rd", rd_seen, 0);
         check("t5_stall_wr", wr_seen, 0);
         check("t5_stall_busy", busy, 1);
         check("t5_stall_nrd", n_rd, 4);
      end
      wait_done("t5", 400);
      check_run("t5", 2, 4, 6, 2, 6);
      mac_lat = 2;

      // 6: reset mid-ISSUE of neuron 1, then a clean restart
      wmem = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
      start_run();
      for (int n = 0; n < 50 && n_rd < 6; n++) @(negedge clk);
      check("t6_pre_busy", busy, 1);
      reset = 1'b1;
      #1;
      check_zero("t6_rst");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("t6_quiet_rd", n_rd, 0);
      start_run();
      wait_done("t6", 200);
      check_run("t6", 4, 3, 2, 0, 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time limit so the bench always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
